mux_sel_scheduler: RTL and testbench
====================================

// Module: mux_sel_scheduler
// PURPOSE
//  Round-robin scheduler that shares the 14-input, 8-bit select mux (Mux16to1) among 14 requesters.
//  Arbitrates pending requests and drives the mux Sel, waits one settle cycle, then registers the mux output.
//  Presents the captured word downstream on a valid/ready handshake and pulses a one-hot Grant back to the served requester.
//  Sits between the DSP input sources and the processing pipeline.
// PARAMETERS
//  NUM_IN  14  number of requesters / used mux inputs (1..16)
//  DATA_W  8   mux data width
//  SEL_W   4   mux select width (ceil(log2(NUM_IN)))
// PORTS
//  Clk        in   1        system clock, all logic on rising edge
//  Rst        in   1        synchronous reset, active-high
//  Req        in   NUM_IN   per-requester request, level; held until own Grant
//  Grant      out  NUM_IN   one-hot, 1-cycle pulse when requester's word is captured
//  Sel        out  SEL_W    mux select, registered
//  MuxOut     in   DATA_W   mux Out, fed back from the mux
//  DataOut    out  DATA_W   captured word, registered
//  DataValid  out  1        DataOut holds a valid word
//  DataReady  in   1        downstream accepts DataOut on a cycle where DataValid&&DataReady
//  Busy       out  1        FSM is not IDLE
// BEHAVIOUR
//  Reset: Sel=0, Grant=0, DataOut=0, DataValid=0, Busy=0, state=IDLE, last pointer Ptr=NUM_IN-1 (search starts at 0).
//  Rst has priority over every event, including mid-handshake; any held word is discarded without a Grant.
//  Arbitration: combinational search from (Ptr+1) mod NUM_IN upward, wrapping; the first set Req bit wins.
//  FSM:
//   IDLE: if |Req then Sel<=winner and go to SELECT; otherwise stay.
//   SELECT: settle cycle. If Req[Sel] is still 1, then DataOut<=MuxOut, Grant[Sel]<=1 (1 cycle), Ptr<=Sel,
//           DataValid<=1, and go to HOLD. If Req[Sel] has dropped, abort to IDLE: no capture, no Grant, Ptr unchanged.
//   HOLD: DataValid=1 and DataOut stays stable until DataReady. On handshake DataValid<=0, then:
//         if |Req, arbitrate in the same cycle, Sel<=winner and go to SELECT; otherwise go to IDLE.
//  Latency: Req seen in IDLE at cycle t -> Sel valid at t+1 -> Grant and DataValid at t+2.
//  Throughput: with DataReady=1, one word every 2 cycles (HOLD -> SELECT -> HOLD).
//  Sel always stays in 0..NUM_IN-1. The mux default arm does not drive Out, so values >= NUM_IN are forbidden.
//  Sel holds its last value outside SELECT. Grant is 0 in every cycle except the capture edge.
//  A requester whose Req is still set in the cycle after its Grant is treated as a new request.
//  Round robin then serves it only after every other pending requester.
//  Ptr wraps from NUM_IN-1 to 0. No requester waits more than NUM_IN grants.
// TESTING
//  Reset: Rst=1 for 2 cycles -> Sel=0, Grant=0, DataValid=0, DataOut=0, Busy=0.
//  Single request: Req=14'h0008, mux In3=8'hA5, DataReady=1 -> Sel=3 at t+1; Grant=14'h0008, DataValid=1, DataOut=8'hA5 at t+2.
//  All requesters: Req=14'h3FFF held, each Req dropping after its Grant, DataReady=1 -> Grant order 0,1,...,13, one every 2 cycles, no repeats.
//  Fairness and wrap: Ptr=12, Req=14'h3001 -> serve 13 then 0, never 12.
//  Backpressure: DataReady=0 for 5 cycles in HOLD -> DataOut and DataValid stable, Sel unchanged, no new Grant.
//  Withdraw and reset: Req[5] drops in SELECT -> IDLE, no Grant. Rst asserted in HOLD -> DataValid=0 the next cycle, Ptr=NUM_IN-1.

Source files
------------

// File: rtl/mux_sel_scheduler.sv
// rtl/mux_sel_scheduler.sv - round-robin scheduler sharing one select mux among NUM_IN requesters
// Picks a requester, drives Sel, captures MuxOut after one settle cycle and offers it on a valid/ready port.
module mux_sel_scheduler #(
  parameter int NUM_IN = 14,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_IN-1:0] Req,
  output logic [NUM_IN-1:0] Grant,
  output logic [SEL_W-1:0]  Sel,
  input  logic [DATA_W-1:0] MuxOut,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  input  logic              DataReady,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] hi_w;
  logic [SEL_W-1:0] lo_w;
  logic             hi_found;
  logic             any_req;

  assign any_req = |Req;
  assign Busy    = (state != IDLE);

  // Lowest set bit above ptr wins; otherwise wrap to the lowest set bit at or below ptr.
  always_comb begin
    hi_w     = '0;
    lo_w     = '0;
    hi_found = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (Req[SEL_W'(i)]) begin
        if (SEL_W'(i) > ptr) begin
          hi_w     = SEL_W'(i);
          hi_found = 1'b1;
        end else begin
          lo_w = SEL_W'(i);
        end
      end
    end
    winner = hi_found ? hi_w : lo_w;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= SEL_W'(NUM_IN - 1);
      Sel       <= '0;
      Grant     <= '0;
      DataOut   <= '0;
      DataValid <= 1'b0;
    end else begin
      Grant <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            Sel   <= winner;
            state <= SELECT;
          end
        end
        SELECT: begin
          // A requester that withdrew during the settle cycle is dropped without service.
          if (Req[Sel]) begin
            DataOut   <= MuxOut;
            Grant     <= NUM_IN'(1) << Sel;
            ptr       <= Sel;
            DataValid <= 1'b1;
            state     <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (DataReady) begin
            DataValid <= 1'b0;
            if (any_req) begin
              Sel   <= winner;
              state <= SELECT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// tb/tb_mux_sel_scheduler.sv - self-checking bench for mux_sel_scheduler
// Table vectors, directed corner sequences and a randomized run against a round-robin reference model.
module tb_mux_sel_scheduler;

  localparam int N = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [3:0]   sel;
  logic [7:0]   mux_out;
  logic [7:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic [7:0]   mux_in [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux_out = mux_in[sel];

  mux_sel_scheduler #(.NUM_IN(N), .DATA_W(8), .SEL_W(4)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Req       (req),
    .Grant     (grant),
    .Sel       (sel),
    .MuxOut    (mux_out),
    .DataOut   (data_out),
    .DataValid (data_valid),
    .DataReady (data_ready),
    .Busy      (busy)
  );

  typedef struct {
    logic [N-1:0] req;
    int           sel;
    logic [7:0]   dout;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: scan upward from the last served index, modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (p + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  logic [N-1:0] rq, h1, h2;
  int           ptr_m;
  int           wait_cnt [N];
  logic         prev_dv, prev_rdy;
  logic [7:0]   prev_dout;
  int           k, last_c, w;

  initial begin
    vecs[0] = '{14'h0008, 3,  8'hA5};
    vecs[1] = '{14'h0009, 0,  8'h0F};
    vecs[2] = '{14'h0009, 3,  8'hA5};
    vecs[3] = '{14'h2000, 13, 8'hD2};
    vecs[4] = '{14'h3001, 0,  8'h0F};
    vecs[5] = '{14'h1010, 4,  8'h4B};
    vecs[6] = '{14'h1010, 12, 8'hC3};
    vecs[7] = '{14'h3001, 13, 8'hD2};
    vecs[8] = '{14'h3001, 0,  8'h0F};
    vecs[9] = '{14'h0400, 10, 8'hA5};

    for (int i = 0; i < 16; i++) mux_in[i] = {4'(i), 4'(15 - i)};
    mux_in[3] = 8'hA5;

    rst = 1'b1; req = '0; data_ready = 1'b1;
    tick(); tick();
    check("rst_sel",   32'(sel), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_dout",  32'(data_out), 0);
    check("rst_busy",  32'(busy), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d_sel", i),   32'(sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_busy", i),  32'(busy), 1);
      check($sformatf("vec%0d_nogr", i),  32'(grant), 0);
      tick();
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(14'(1) << vecs[i].sel));
      check($sformatf("vec%0d_valid", i), 32'(data_valid), 1);
      check($sformatf("vec%0d_dout", i),  32'(data_out), 32'(vecs[i].dout));
      req = '0;
      tick();
      check($sformatf("vec%0d_done", i),  32'(data_valid), 0);
      check($sformatf("vec%0d_idle", i),  32'(busy), 0);
    end

    // Every requester at once: expect 0..13, two cycles apart.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 14'h3FFF; k = 0; last_c = 0;
    for (int c = 0; c < 60 && k < N; c++) begin
      tick();
      if (grant != '0) begin
        check("all_order", 32'(grant), 32'(14'(1) << k));
        if (k > 0) check("all_spacing", 32'(c - last_c), 2);
        last_c = c;
        req = req & ~grant;
        k++;
      end
    end
    check("all_count", 32'(k), 32'(N));
    req = '0;
    tick(); tick();

    // Backpressure in HOLD, with a competing request waiting.
    req = 14'h0020; data_ready = 1'b0;
    tick(); tick();
    check("bp_grant", 32'(grant), 32'h20);
    check("bp_dout0", 32'(data_out), 32'h5A);
    req = 14'h0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", 32'(data_valid), 1);
      check("bp_dout",  32'(data_out), 32'h5A);
      check("bp_sel",   32'(sel), 5);
      check("bp_nogr",  32'(grant), 0);
    end
    data_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(data_valid), 0);
    check("bp_release_sel",   32'(sel), 8);
    check("bp_release_busy",  32'(busy), 1);
    tick();
    check("bp_next_grant", 32'(grant), 32'h100);
    check("bp_next_dout",  32'(data_out), 32'h87);
    req = '0;
    tick();
    check("bp_end_idle", 32'(busy), 0);

    // Withdraw during the settle cycle; the pointer must stay at 8.
    req = 14'h0020;
    tick();
    check("wd_sel", 32'(sel), 5);
    req = '0;
    tick();
    check("wd_nogr",  32'(grant), 0);
    check("wd_valid", 32'(data_valid), 0);
    check("wd_idle",  32'(busy), 0);
    req = 14'h0240;
    tick();
    check("wd_ptr_sel", 32'(sel), 9);
    tick();
    check("wd_ptr_grant", 32'(grant), 32'h200);
    req = '0;
    tick();

    // Reset while holding a word.
    data_ready = 1'b0; req = 14'h0004;
    tick(); tick();
    check("rh_grant", 32'(grant), 32'h4);
    rst = 1'b1; req = '0;
    tick();
    check("rh_valid", 32'(data_valid), 0);
    check("rh_busy",  32'(busy), 0);
    check("rh_sel",   32'(sel), 0);
    check("rh_dout",  32'(data_out), 0);
    rst = 1'b0; data_ready = 1'b1; req = 14'h2002;
    tick();
    check("rh_ptr_sel", 32'(sel), 1);
    tick();
    check("rh_ptr_grant", 32'(grant), 32'h2);
    req = '0;
    tick();

    // Randomized traffic against the round-robin model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      mux_in[i] = 8'($urandom);
      wait_cnt[i] = 0;
    end
    rq = '0; h1 = '0; h2 = '0; ptr_m = N - 1;
    prev_dv = 1'b0; prev_rdy = 1'b1; prev_dout = '0;
    req = '0; data_ready = 1'b1;
    for (int c = 0; c < 3200; c++) begin
      tick();
      if (prev_dv && !prev_rdy) begin
        check("rnd_hold_valid", 32'(data_valid), 1);
        check("rnd_hold_dout",  32'(data_out), 32'(prev_dout));
        check("rnd_hold_nogr",  32'(grant), 0);
      end
      if (grant != '0) begin
        w = rr_pick(h2, ptr_m);
        check("rnd_onehot", 32'($countones(grant)), 1);
        check("rnd_winner", 32'(grant), (w >= 0) ? 32'(14'(1) << w) : 32'h0);
        check("rnd_valid",  32'(data_valid), 1);
        if (w >= 0) begin
          check("rnd_data", 32'(data_out), 32'(mux_in[w]));
          check("rnd_wait_bound", 32'(wait_cnt[w] <= N), 1);
          for (int j = 0; j < N; j++)
            if (j != w && rq[j]) wait_cnt[j]++;
          wait_cnt[w] = 0;
          ptr_m = w;
        end
        rq = rq & ~grant;
      end
      if (c < 3000) begin
        for (int j = 0; j < N; j++)
          if (!rq[j] && $urandom_range(0, 5) == 0) rq[j] = 1'b1;
      end
      data_ready = (c >= 3000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      prev_dv   = data_valid;
      prev_rdy  = data_ready;
      prev_dout = data_out;
      h2  = h1;
      h1  = rq;
      req = rq;
    end
    check("rnd_drained", 32'(rq), 0);
    check("rnd_final_valid", 32'(data_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
